// File: rtl/stopwatch_pkg.sv
// Shared constants, types and helpers for the stopwatch display scanner.
// Segment and anode levels are active-low, so "all ones" means dark.
package stopwatch_pkg;

  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [3:0] AN_OFF    = 4'b1111;

  localparam int DEF_SCAN_DIV    = 100000;
  localparam int DEF_DEAD_CYCLES = 16;
  localparam int DEF_BLINK_DIV   = 25000000;

  typedef enum logic [1:0] {
    SLOT_IDLE,
    SLOT_DEAD,
    SLOT_LIT
  } slot_state_e;

  // sel=0 picks the minutes pair (digits 3,2); sel=1 picks the seconds pair (digits 1,0).
  function automatic logic inSelPair(input logic [1:0] idx, input logic sel);
    return sel ? ~idx[1] : idx[1];
  endfunction

endpackage

// File: rtl/seg_display_scanner_tick_gen.sv
// Free-running divider that counts 0..DIV-1 while enabled and flags the last count.
// The clear input parks the counter at zero so a new run always starts fresh.
module tick_gen #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic i_rst,
  input  logic i_en,
  input  logic i_clr,
  output logic o_tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] r_count;
  logic          w_atLast;

  assign w_atLast = (r_count == LAST);
  assign o_tick   = i_en && w_atLast;

  always_ff @(posedge clk) begin
    if (i_rst || i_clr) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= w_atLast ? '0 : r_count + CW'(1);
    end
  end

endmodule

// File: rtl/seg_display_scanner.sv
// Time-multiplexes four active-low seven-segment digits onto one panel, with
// anode dead time between slots, per-frame input snapshot and adjust-mode blink.
module seg_display_scanner
  import stopwatch_pkg::*;
#(
  parameter int SCAN_DIV    = DEF_SCAN_DIV,
  parameter int DEAD_CYCLES = DEF_DEAD_CYCLES,
  parameter int BLINK_DIV   = DEF_BLINK_DIV
) (
  input  logic       clk,
  input  logic       RESET,
  input  logic [7:0] digit0_display,
  input  logic [7:0] digit1_display,
  input  logic [7:0] digit2_display,
  input  logic [7:0] digit3_display,
  input  logic       adj,
  input  logic       sel,
  output logic [3:0] an,
  output logic [7:0] seg
);

  localparam int DW = (DEAD_CYCLES > 1) ? $clog2(DEAD_CYCLES) : 1;
  localparam logic [DW-1:0] DEAD_LAST = (DEAD_CYCLES > 0) ? DW'(DEAD_CYCLES - 1) : '0;

  logic             w_scanTick;
  logic             w_blinkTick;
  logic             r_blinkPhase;
  logic [1:0]       r_idx;
  logic [1:0]       w_idxNext;
  logic [3:0][7:0]  r_frame;
  logic [3:0][7:0]  w_inDigits;
  logic [3:0][7:0]  w_srcDigits;
  logic [7:0]       w_pattern;
  logic             w_wrap;
  logic             w_blank;
  logic [DW-1:0]    r_deadCnt;
  logic             w_deadDone;
  logic [3:0]       r_an;
  logic [7:0]       r_seg;
  slot_state_e      r_state;
  slot_state_e      w_stateNext;

  tick_gen #(.DIV(SCAN_DIV)) u_scanDiv (
    .clk    (clk),
    .i_rst  (RESET),
    .i_en   (1'b1),
    .i_clr  (1'b0),
    .o_tick (w_scanTick)
  );

  tick_gen #(.DIV(BLINK_DIV)) u_blinkDiv (
    .clk    (clk),
    .i_rst  (RESET),
    .i_en   (adj),
    .i_clr  (~adj),
    .o_tick (w_blinkTick)
  );

  assign w_inDigits  = {digit3_display, digit2_display, digit1_display, digit0_display};
  assign w_wrap      = (r_idx == 2'd3);
  assign w_idxNext   = w_scanTick ? r_idx + 2'd1 : r_idx;
  // Digit 0 comes straight from the inputs being snapshotted, so a frame never mixes two counts.
  assign w_srcDigits = w_wrap ? w_inDigits : r_frame;
  assign w_pattern   = w_srcDigits[w_idxNext];
  assign w_blank     = adj && r_blinkPhase && inSelPair(w_idxNext, sel);
  assign w_deadDone  = (r_deadCnt == DEAD_LAST);

  always_comb begin
    w_stateNext = r_state;
    if (w_scanTick) begin
      w_stateNext = (DEAD_CYCLES == 0) ? SLOT_LIT : SLOT_DEAD;
    end else if (r_state == SLOT_DEAD && w_deadDone) begin
      w_stateNext = SLOT_LIT;
    end
  end

  always_ff @(posedge clk) begin
    if (RESET) begin
      r_state   <= SLOT_IDLE;
      r_deadCnt <= '0;
      r_an      <= AN_OFF;
    end else begin
      r_state <= w_stateNext;
      if (w_scanTick) begin
        r_deadCnt <= '0;
      end else if (r_state == SLOT_DEAD && !w_deadDone) begin
        r_deadCnt <= r_deadCnt + DW'(1);
      end
      r_an <= (w_stateNext == SLOT_LIT) ? ~(4'b0001 << w_idxNext) : AN_OFF;
    end
  end

  always_ff @(posedge clk) begin
    if (RESET) begin
      r_idx   <= 2'd3;
      r_seg   <= SEG_BLANK;
      r_frame <= {4{SEG_BLANK}};
    end else if (w_scanTick) begin
      r_idx <= w_idxNext;
      r_seg <= w_blank ? SEG_BLANK : w_pattern;
      if (w_wrap) begin
        r_frame <= w_inDigits;
      end
    end
  end

  // Blink phase only runs in adjust mode so every entry starts with a visible half-period.
  always_ff @(posedge clk) begin
    if (RESET || !adj) begin
      r_blinkPhase <= 1'b0;
    end else if (w_blinkTick) begin
      r_blinkPhase <= ~r_blinkPhase;
    end
  end

  assign an  = r_an;
  assign seg = r_seg;

endmodule

// File: doc/seg_display_scanner.md
SEG_DISPLAY_SCANNER -- requirements
Module: seg_display_scanner

Interface
REQ-001 Parameter SCAN_DIV, default 100000: clk cycles per digit slot; legal range 2 and above.
REQ-002 Parameter DEAD_CYCLES, default 16: anode-off cycles at the start of each slot; legal range 0 to SCAN_DIV-1.
REQ-003 Parameter BLINK_DIV, default 25000000: clk cycles per blink half-period; legal range 1 and above.
REQ-004 Port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 Port RESET, input, 1 bit: synchronous, active-high reset.
REQ-006 Ports digit0_display..digit3_display, input, 8 bits each: active-low segment patterns {dp,g..a}; digit0 is the rightmost digit (seconds ones), digit3 is the leftmost (minutes tens).
REQ-007 Port adj, input, 1 bit: 1 = adjust mode active.
REQ-008 Port sel, input, 1 bit: 0 = minutes pair (digits 3,2) is being adjusted; 1 = seconds pair (digits 1,0) is being adjusted.
REQ-009 Port an, output, 4 bits: active-low anodes; an[i] enables digit i.
REQ-010 Port seg, output, 8 bits: active-low segments driven to the panel.

Function
REQ-011 A scan counter SHALL count 0..SCAN_DIV-1 and wrap; scan_tick SHALL be asserted while count == SCAN_DIV-1.
REQ-012 On each scan_tick edge, the digit index idx SHALL advance by one (0,1,2,3,0 ...) and an SHALL go to 4'b1111.
REQ-013 DEAD_CYCLES edges after the tick edge, an[idx] SHALL go low; all other an bits SHALL stay high; an SHALL hold until the next tick.
REQ-014 If DEAD_CYCLES = 0, an[idx] SHALL go low on the tick edge itself.
REQ-015 seg SHALL update on the tick edge to the pattern for the new idx and SHALL hold for the whole slot.
REQ-016 Frame snapshot: on the tick edge where idx wraps 3->0, all four digit inputs SHALL be captured into frame registers.
REQ-017 seg for idx 0 SHALL come from the inputs at that wrap edge; idx 1-3 SHALL come from the frame registers, so that no frame mixes two counter values.
REQ-018 A blink counter SHALL count 0..BLINK_DIV-1 and toggle blink_phase on wrap, but only while adj = 1.
REQ-019 While adj = 0, the blink counter SHALL be held at 0 and blink_phase at 0.
REQ-020 When adj rises, the first BLINK_DIV cycles SHALL be visible (blink_phase = 0).
REQ-021 If adj falls mid-blink, blink_phase SHALL be 0 on the next edge; a slot already in progress keeps its seg value until the next tick.
REQ-022 Blanking: when a pattern is loaded into seg with adj = 1 and blink_phase = 1, seg SHALL be 8'hFF if idx is in the selected pair (sel=0: idx 2,3; sel=1: idx 0,1); otherwise seg SHALL be the digit pattern.
REQ-023 A sel change SHALL take effect at the next tick edge; the frame snapshot is unaffected.
REQ-024 At most one an bit SHALL be low in any cycle.

Reset
REQ-025 With RESET = 1 at an edge: an = 4'b1111, seg = 8'hFF, idx = 3, scan counter = 0, blink counter = 0, blink_phase = 0, frame registers = 8'hFF.
REQ-026 RESET SHALL take priority over all other activity, including mid-slot and mid-dead-time.
REQ-027 The first tick after reset SHALL wrap idx to 0 and perform a snapshot (REQ-016).

Structure
REQ-028 Package stopwatch_pkg SHALL hold SEG_BLANK = 8'hFF, AN_OFF = 4'b1111 and the default SCAN_DIV, DEAD_CYCLES and BLINK_DIV values.
REQ-029 One sub-module, tick_gen, SHALL be used: a parameterised divider with enable and synchronous clear that outputs a one-cycle tick; it is instantiated for both the scan counter and the blink counter.
REQ-030 Target size is 120-400 RTL lines; no latches and no derived clocks.

Verification (SCAN_DIV=4, DEAD_CYCLES=1, BLINK_DIV=8)
REQ-031 Release reset with digits {3..0} = 8'hA4, 8'hB0, 8'h99, 8'hC0: first tick gives seg = 8'hC0 and an = 4'b1111; one cycle later an = 4'b1110; idx then sequences 1,2,3 with seg = 99, B0, A4 and an = 1101, 1011, 0111.
REQ-032 Change digit2_display to 8'h92 during slot 1: slot 2 of the same frame still shows 8'hB0; the next frame shows 8'h92.
REQ-033 Set adj=1, sel=1 and run 64 cycles: idx 0/1 slots alternate between the patterns and 8'hFF every 8 cycles; idx 2/3 slots are never blank.
REQ-034 Set adj=1, sel=0, wait until blink_phase=1, then drop adj: blink_phase = 0 on the next edge, and all slots from the next tick onward are unblanked.
REQ-035 Assert RESET for 1 cycle during a dead-time cycle: next edge gives an = 1111 and seg = FF; recovery proceeds exactly as in REQ-031.
REQ-036 Checker on every cycle: an is one of 1111, 1110, 1101, 1011, 0111.
